// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: registered IF/ID/EXE/MEM/WB sequencer that emits datapath strobes,
// waits on instruction/data memory acks for a bounded time, and parks in sticky HALT/FAULT status.
module mc_control_unit #(
   parameter int HANDSHAKE = 1,
   parameter int WAIT_MAX  = 16
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       sign,
   input  logic       iack,
   input  logic       dack,
   output logic       ireq,
   output logic       dreq,
   output logic       PCWre,
   output logic       IRWre,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic [2:0] ALUOp,
   output logic       DBDataSrc,
   output logic       nRD,
   output logic       nWR,
   output logic [1:0] PCSrc,
   output logic [2:0] state,
   output logic       halted,
   output logic       fault
);
   localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EXE_LS = 3'b010, S_MEM = 3'b011,
                          S_WB_LD = 3'b100, S_EXE_BR = 3'b101, S_EXE_AL = 3'b110, S_WB_AL = 3'b111;
   localparam logic [1:0] ST_RUN = 2'b00, ST_HALT = 2'b01, ST_FAULT = 2'b10;

   localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b010000,
                          OP_OR = 6'b010001, OP_SLL = 6'b011000, OP_SLT = 6'b100110,
                          OP_ADDIU = 6'b000010, OP_ANDI = 6'b010010, OP_ORI = 6'b010011,
                          OP_SLTI = 6'b100111, OP_SW = 6'b110000, OP_LW = 6'b110001,
                          OP_BEQ = 6'b110100, OP_BNE = 6'b110101, OP_BLTZ = 6'b110110,
                          OP_J = 6'b111000, OP_JR = 6'b111001, OP_JAL = 6'b111010,
                          OP_HALT = 6'b111111;

   localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   logic [2:0]       st, st_nxt;
   logic [1:0]       stat, stat_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic       is_r, is_i, is_mem, is_br, is_jmp, is_halt, ext_s;
   logic [2:0] alu_op;
   logic       i_ack, d_ack, taken;

   assign i_ack = (HANDSHAKE == 0) ? 1'b1 : iack;
   assign d_ack = (HANDSHAKE == 0) ? 1'b1 : dack;
   assign taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero) ||
                  ((opcode == OP_BLTZ) && sign);

   always_comb begin
      is_r = 1'b0; is_i = 1'b0; is_mem = 1'b0; is_br = 1'b0;
      is_jmp = 1'b0; is_halt = 1'b0; ext_s = 1'b0; alu_op = 3'b000;
      case (opcode)
         OP_ADD:   begin is_r = 1'b1; alu_op = 3'b000; end
         OP_SUB:   begin is_r = 1'b1; alu_op = 3'b001; end
         OP_AND:   begin is_r = 1'b1; alu_op = 3'b100; end
         OP_OR:    begin is_r = 1'b1; alu_op = 3'b011; end
         OP_SLL:   begin is_r = 1'b1; alu_op = 3'b010; end
         OP_SLT:   begin is_r = 1'b1; alu_op = 3'b101; end
         OP_ADDIU: begin is_i = 1'b1; alu_op = 3'b000; ext_s = 1'b1; end
         OP_ANDI:  begin is_i = 1'b1; alu_op = 3'b100; end
         OP_ORI:   begin is_i = 1'b1; alu_op = 3'b011; end
         OP_SLTI:  begin is_i = 1'b1; alu_op = 3'b101; ext_s = 1'b1; end
         OP_SW, OP_LW:            is_mem = 1'b1;
         OP_BEQ, OP_BNE, OP_BLTZ: is_br = 1'b1;
         OP_J, OP_JR, OP_JAL:     is_jmp = 1'b1;
         OP_HALT:                 is_halt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         st   <= S_IF;
         stat <= ST_RUN;
         cnt  <= '0;
      end else begin
         st   <= st_nxt;
         stat <= stat_nxt;
         cnt  <= cnt_nxt;
      end
   end

   // The wait counter only advances while IF/MEM stall; every other path clears it.
   always_comb begin
      st_nxt   = st;
      stat_nxt = stat;
      cnt_nxt  = '0;
      if (stat == ST_RUN) begin
         case (st)
            S_IF:
               if (i_ack)                st_nxt = S_ID;
               else if (cnt == CNT_LAST) stat_nxt = ST_FAULT;
               else                      cnt_nxt = cnt + CNT_W'(1);
            S_ID:
               if (is_r || is_i)  st_nxt = S_EXE_AL;
               else if (is_mem)   st_nxt = S_EXE_LS;
               else if (is_br)    st_nxt = S_EXE_BR;
               else if (is_jmp)   st_nxt = S_IF;
               else if (is_halt)  begin st_nxt = S_IF; stat_nxt = ST_HALT; end
               else               begin st_nxt = S_IF; stat_nxt = ST_FAULT; end
            S_EXE_LS: st_nxt = S_MEM;
            S_MEM:
               if (d_ack)                st_nxt = (opcode == OP_LW) ? S_WB_LD : S_IF;
               else if (cnt == CNT_LAST) stat_nxt = ST_FAULT;
               else                      cnt_nxt = cnt + CNT_W'(1);
            S_EXE_AL: st_nxt = S_WB_AL;
            default:  st_nxt = S_IF;
         endcase
      end
   end

   always_comb begin
      ireq = 1'b0; dreq = 1'b0; PCWre = 1'b0; IRWre = 1'b0; RegWre = 1'b0;
      RegDst = 2'b00; WrRegDSrc = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ExtSel = 1'b0;
      ALUOp = 3'b000; DBDataSrc = 1'b0; nRD = 1'b1; nWR = 1'b1; PCSrc = 2'b00;
      state = 3'b000;
      halted = !Reset && (stat == ST_HALT);
      fault  = !Reset && (stat == ST_FAULT);
      if (!Reset && (stat == ST_RUN)) begin
         state = st;
         case (st)
            S_IF: begin
               ireq  = 1'b1;
               IRWre = i_ack;
            end
            S_ID:
               if (is_jmp) begin
                  PCWre = 1'b1;
                  PCSrc = (opcode == OP_JR) ? 2'b10 : 2'b11;
                  if (opcode == OP_JAL) RegWre = 1'b1;
               end
            S_EXE_AL: begin
               ALUOp   = alu_op;
               ALUSrcA = (opcode == OP_SLL);
               ALUSrcB = is_i;
               ExtSel  = ext_s;
            end
            S_WB_AL: begin
               RegWre    = 1'b1;
               WrRegDSrc = 1'b1;
               RegDst    = is_r ? 2'b10 : 2'b01;
               PCWre     = 1'b1;
            end
            S_EXE_LS: begin
               ALUSrcB = 1'b1;
               ExtSel  = 1'b1;
            end
            S_MEM: begin
               dreq = 1'b1;
               nRD  = (opcode != OP_LW);
               nWR  = (opcode != OP_SW);
               PCWre = d_ack && (opcode == OP_SW);
            end
            S_WB_LD: begin
               RegWre    = 1'b1;
               DBDataSrc = 1'b1;
               WrRegDSrc = 1'b1;
               RegDst    = 2'b01;
               PCWre     = 1'b1;
            end
            S_EXE_BR: begin
               ALUOp  = 3'b001;
               ExtSel = 1'b1;
               PCWre  = 1'b1;
               PCSrc  = taken ? 2'b01 : 2'b00;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one handshake instance (WAIT_MAX=4) and one zero-wait instance,
// every cycle compared as a whole strobe vector against hand-derived expectations.
module tb_mc_control_unit;
   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b010000, OR_ = 6'b010001,
                          SLL = 6'b011000, SLT = 6'b100110, ADDIU = 6'b000010, ANDI = 6'b010010,
                          ORI = 6'b010011, SLTI = 6'b100111, SW = 6'b110000, LW = 6'b110001,
                          BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110, J = 6'b111000,
                          JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111, ILL = 6'b101010;

   typedef struct packed {
      logic [2:0] st;
      logic ireq, dreq, pcw, irw, rw;
      logic [1:0] rdst;
      logic wsrc, asa, asb, ext;
      logic [2:0] op;
      logic dbs, nrd, nwr;
      logic [1:0] pcs;
      logic hl, ft;
   } sig_t;

   logic CLK = 1'b0, Reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic zero = 1'b0, sign = 1'b0, iack = 1'b0, dack = 1'b0;
   int checks = 0, failures = 0;
   sig_t e, s_h, s_n;

   always #5 CLK = ~CLK;

   logic ireq_h, dreq_h, PCWre_h, IRWre_h, RegWre_h, WrRegDSrc_h, ALUSrcA_h, ALUSrcB_h, ExtSel_h;
   logic DBDataSrc_h, nRD_h, nWR_h, halted_h, fault_h;
   logic [1:0] RegDst_h, PCSrc_h;
   logic [2:0] ALUOp_h, state_h;
   logic ireq_n, dreq_n, PCWre_n, IRWre_n, RegWre_n, WrRegDSrc_n, ALUSrcA_n, ALUSrcB_n, ExtSel_n;
   logic DBDataSrc_n, nRD_n, nWR_n, halted_n, fault_n;
   logic [1:0] RegDst_n, PCSrc_n;
   logic [2:0] ALUOp_n, state_n;

   mc_control_unit #(.HANDSHAKE(1), .WAIT_MAX(4)) dut_h (
      .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign), .iack(iack), .dack(dack),
      .ireq(ireq_h), .dreq(dreq_h), .PCWre(PCWre_h), .IRWre(IRWre_h), .RegWre(RegWre_h),
      .RegDst(RegDst_h), .WrRegDSrc(WrRegDSrc_h), .ALUSrcA(ALUSrcA_h), .ALUSrcB(ALUSrcB_h),
      .ExtSel(ExtSel_h), .ALUOp(ALUOp_h), .DBDataSrc(DBDataSrc_h), .nRD(nRD_h), .nWR(nWR_h),
      .PCSrc(PCSrc_h), .state(state_h), .halted(halted_h), .fault(fault_h));

   mc_control_unit #(.HANDSHAKE(0), .WAIT_MAX(16)) dut_n (
      .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign), .iack(iack), .dack(dack),
      .ireq(ireq_n), .dreq(dreq_n), .PCWre(PCWre_n), .IRWre(IRWre_n), .RegWre(RegWre_n),
      .RegDst(RegDst_n), .WrRegDSrc(WrRegDSrc_n), .ALUSrcA(ALUSrcA_n), .ALUSrcB(ALUSrcB_n),
      .ExtSel(ExtSel_n), .ALUOp(ALUOp_n), .DBDataSrc(DBDataSrc_n), .nRD(nRD_n), .nWR(nWR_n),
      .PCSrc(PCSrc_n), .state(state_n), .halted(halted_n), .fault(fault_n));

   assign s_h = {state_h, ireq_h, dreq_h, PCWre_h, IRWre_h, RegWre_h, RegDst_h, WrRegDSrc_h,
                 ALUSrcA_h, ALUSrcB_h, ExtSel_h, ALUOp_h, DBDataSrc_h, nRD_h, nWR_h, PCSrc_h,
                 halted_h, fault_h};
   assign s_n = {state_n, ireq_n, dreq_n, PCWre_n, IRWre_n, RegWre_n, RegDst_n, WrRegDSrc_n,
                 ALUSrcA_n, ALUSrcB_n, ExtSel_n, ALUOp_n, DBDataSrc_n, nRD_n, nWR_n, PCSrc_n,
                 halted_n, fault_n};

   function automatic sig_t idle_at(input logic [2:0] s);
      sig_t r;
      r = '0;
      r.st = s;
      r.nrd = 1'b1;
      r.nwr = 1'b1;
      return r;
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rise.
   task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic sg,
                      input logic ia, input logic da);
      @(negedge CLK);
      Reset = r; opcode = op; zero = z; sign = sg; iack = ia; dack = da;
      #1;
   endtask

   task automatic test_reset;
      cyc(1, ADD, 0, 0, 1, 1);
      e = idle_at(3'd0);
      checks++; if (s_h !== e) begin failures++; $display("FAIL reset_h got=%h exp=%h", s_h, e); end
      checks++; if (s_n !== e) begin failures++; $display("FAIL reset_n got=%h exp=%h", s_n, e); end
      cyc(0, ADD, 0, 0, 1, 1);
      e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL first_if_h got=%h exp=%h", s_h, e); end
      checks++; if (s_n !== e) begin failures++; $display("FAIL first_if_n got=%h exp=%h", s_n, e); end
   endtask

   task automatic test_alu;
      logic [5:0] ops [10] = '{ADD, SUB, SLL, ORI, ADDIU, SLTI, ANDI, AND_, OR_, SLT};
      logic [2:0] aop [10] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b101, 3'b100, 3'b100,
                               3'b011, 3'b101};
      logic [9:0] asa = 10'b0000000100;
      logic [9:0] asb = 10'b0001111000;
      logic [9:0] ext = 10'b0000110000;
      cyc(1, ADD, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         cyc(0, ops[k], 0, 0, 0, 0);
         e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
         checks++; if (s_n !== e) begin failures++; $display("FAIL alu_if k=%0d got=%h exp=%h", k, s_n, e); end
         cyc(0, ops[k], 0, 0, 0, 0);
         e = idle_at(3'd1);
         checks++; if (s_n !== e) begin failures++; $display("FAIL alu_id k=%0d got=%h exp=%h", k, s_n, e); end
         cyc(0, ops[k], 0, 0, 0, 0);
         e = idle_at(3'd6); e.op = aop[k]; e.asa = asa[k]; e.asb = asb[k]; e.ext = ext[k];
         checks++; if (s_n !== e) begin failures++; $display("FAIL alu_exe k=%0d got=%h exp=%h", k, s_n, e); end
         cyc(0, ops[k], 0, 0, 0, 0);
         e = idle_at(3'd7); e.rw = 1; e.wsrc = 1; e.pcw = 1;
         e.rdst = asb[k] ? 2'b01 : 2'b10;
         checks++; if (s_n !== e) begin failures++; $display("FAIL alu_wb k=%0d got=%h exp=%h", k, s_n, e); end
      end
   endtask

   task automatic test_lw_wait;
      cyc(1, LW, 0, 0, 0, 0);
      cyc(0, LW, 0, 0, 1, 0);
      e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL lw_if got=%h exp=%h", s_h, e); end
      cyc(0, LW, 0, 0, 0, 0);
      e = idle_at(3'd1);
      checks++; if (s_h !== e) begin failures++; $display("FAIL lw_id got=%h exp=%h", s_h, e); end
      cyc(0, LW, 0, 0, 0, 0);
      e = idle_at(3'd2); e.asb = 1; e.ext = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL lw_exe got=%h exp=%h", s_h, e); end
      for (int i = 0; i < 4; i++) begin
         cyc(0, LW, 0, 0, 0, (i == 3));
         e = idle_at(3'd3); e.dreq = 1; e.nrd = 0;
         checks++; if (s_h !== e) begin failures++; $display("FAIL lw_mem i=%0d got=%h exp=%h", i, s_h, e); end
      end
      cyc(0, LW, 0, 0, 0, 0);
      e = idle_at(3'd4); e.rw = 1; e.dbs = 1; e.wsrc = 1; e.rdst = 2'b01; e.pcw = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL lw_wb got=%h exp=%h", s_h, e); end
      cyc(0, LW, 0, 0, 1, 0);
      e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL lw_next got=%h exp=%h", s_h, e); end
   endtask

   task automatic test_branch;
      logic [5:0] ops [6] = '{BEQ, BEQ, BNE, BNE, BLTZ, BLTZ};
      logic [5:0] zv = 6'b100100;
      logic [5:0] sv = 6'b000010;
      logic [5:0] tk = 6'b101010;
      cyc(1, BEQ, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         cyc(0, ops[k], zv[5-k], sv[5-k], 0, 0);
         e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
         checks++; if (s_n !== e) begin failures++; $display("FAIL br_if k=%0d got=%h exp=%h", k, s_n, e); end
         cyc(0, ops[k], zv[5-k], sv[5-k], 0, 0);
         e = idle_at(3'd1);
         checks++; if (s_n !== e) begin failures++; $display("FAIL br_id k=%0d got=%h exp=%h", k, s_n, e); end
         cyc(0, ops[k], zv[5-k], sv[5-k], 0, 0);
         e = idle_at(3'd5); e.op = 3'b001; e.ext = 1; e.pcw = 1; e.pcs = tk[5-k] ? 2'b01 : 2'b00;
         checks++; if (s_n !== e) begin failures++; $display("FAIL br_exe k=%0d got=%h exp=%h", k, s_n, e); end
      end
   endtask

   task automatic test_jump;
      logic [5:0] ops [3] = '{J, JR, JAL};
      logic [1:0] pcs [3] = '{2'b11, 2'b10, 2'b11};
      cyc(1, J, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, ops[k], 0, 0, 0, 0);
         e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
         checks++; if (s_n !== e) begin failures++; $display("FAIL jmp_if k=%0d got=%h exp=%h", k, s_n, e); end
         cyc(0, ops[k], 0, 0, 0, 0);
         e = idle_at(3'd1); e.pcw = 1; e.pcs = pcs[k]; e.rw = (k == 2);
         checks++; if (s_n !== e) begin failures++; $display("FAIL jmp_id k=%0d got=%h exp=%h", k, s_n, e); end
      end
      cyc(0, ADD, 0, 0, 0, 0);
      e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
      checks++; if (s_n !== e) begin failures++; $display("FAIL jmp_next got=%h exp=%h", s_n, e); end
   endtask

   task automatic test_timeout;
      cyc(1, ADD, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, ADD, 0, 0, 0, 0);
         e = idle_at(3'd0); e.ireq = 1;
         checks++; if (s_h !== e) begin failures++; $display("FAIL to_if i=%0d got=%h exp=%h", i, s_h, e); end
      end
      cyc(0, ADD, 0, 0, 0, 0);
      e = idle_at(3'd0); e.ft = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL to_fault got=%h exp=%h", s_h, e); end
      cyc(0, ADD, 0, 0, 1, 1);
      checks++; if (s_h !== e) begin failures++; $display("FAIL to_sticky got=%h exp=%h", s_h, e); end
      cyc(1, ADD, 0, 0, 1, 1);
      e = idle_at(3'd0);
      checks++; if (s_h !== e) begin failures++; $display("FAIL to_rst got=%h exp=%h", s_h, e); end
      for (int i = 0; i < 4; i++) begin
         cyc(0, ADD, 0, 0, (i == 3), 0);
         e = idle_at(3'd0); e.ireq = 1; e.irw = (i == 3);
         checks++; if (s_h !== e) begin failures++; $display("FAIL ok_if i=%0d got=%h exp=%h", i, s_h, e); end
      end
      cyc(0, ADD, 0, 0, 0, 0);
      e = idle_at(3'd1);
      checks++; if (s_h !== e) begin failures++; $display("FAIL ok_id got=%h exp=%h", s_h, e); end
   endtask

   task automatic test_illegal_halt;
      logic [5:0] ops [2] = '{ILL, HALT};
      for (int k = 0; k < 2; k++) begin
         cyc(1, ops[k], 0, 0, 0, 0);
         cyc(0, ops[k], 0, 0, 0, 0);
         cyc(0, ops[k], 0, 0, 0, 0);
         e = idle_at(3'd1);
         checks++; if (s_n !== e) begin failures++; $display("FAIL stop_id k=%0d got=%h exp=%h", k, s_n, e); end
         for (int i = 0; i < 2; i++) begin
            cyc(0, ADD, 0, 0, 1, 1);
            e = idle_at(3'd0); e.ft = (k == 0); e.hl = (k == 1);
            checks++; if (s_n !== e) begin failures++; $display("FAIL stop_st k=%0d i=%0d got=%h exp=%h", k, i, s_n, e); end
         end
      end
      cyc(1, ADD, 0, 0, 0, 0);
      cyc(0, ADD, 0, 0, 0, 0);
      e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
      checks++; if (s_n !== e) begin failures++; $display("FAIL stop_clear got=%h exp=%h", s_n, e); end
   endtask

   task automatic test_reset_mid;
      cyc(1, SW, 0, 0, 0, 0);
      cyc(0, SW, 0, 0, 1, 0);
      cyc(0, SW, 0, 0, 0, 0);
      cyc(0, SW, 0, 0, 0, 0);
      cyc(0, SW, 0, 0, 0, 0);
      e = idle_at(3'd3); e.dreq = 1; e.nwr = 0;
      checks++; if (s_h !== e) begin failures++; $display("FAIL rm_mem got=%h exp=%h", s_h, e); end
      cyc(1, SW, 0, 0, 1, 1);
      e = idle_at(3'd0);
      checks++; if (s_h !== e) begin failures++; $display("FAIL rm_rst got=%h exp=%h", s_h, e); end
      cyc(0, SW, 0, 0, 0, 0);
      e = idle_at(3'd0); e.ireq = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL rm_if got=%h exp=%h", s_h, e); end
   endtask

   task automatic test_back_to_back;
      cyc(1, SW, 0, 0, 0, 0);
      cyc(0, SW, 0, 0, 1, 0);
      cyc(0, SW, 0, 0, 0, 0);
      cyc(0, SW, 0, 0, 0, 0);
      e = idle_at(3'd2); e.asb = 1; e.ext = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL bb_exe got=%h exp=%h", s_h, e); end
      cyc(0, SW, 0, 0, 0, 1);
      e = idle_at(3'd3); e.dreq = 1; e.nwr = 0; e.pcw = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL bb_sw got=%h exp=%h", s_h, e); end
      cyc(0, J, 0, 0, 1, 0);
      e = idle_at(3'd0); e.ireq = 1; e.irw = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL bb_if got=%h exp=%h", s_h, e); end
      cyc(0, J, 0, 0, 0, 0);
      e = idle_at(3'd1); e.pcw = 1; e.pcs = 2'b11;
      checks++; if (s_h !== e) begin failures++; $display("FAIL bb_j got=%h exp=%h", s_h, e); end
      cyc(0, ADD, 0, 0, 0, 0);
      e = idle_at(3'd0); e.ireq = 1;
      checks++; if (s_h !== e) begin failures++; $display("FAIL bb_next got=%h exp=%h", s_h, e); end
   endtask

   initial begin
      test_reset;
      test_alu;
      test_lw_wait;
      test_branch;
      test_jump;
      test_timeout;
      test_illegal_halt;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
